// File: rtl/rot_quad_gen.sv
// Rotary quadrature encoder emulator: AXI-Stream command packets request a
// number of A/B quadrature steps at a given period and direction, with Z index.
module rot_quad_gen #(
    parameter logic [31:0] CNT_PER_REV = 32'd8000,
    parameter logic [15:0] MIN_PERIOD  = 16'd2
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        rot_a,
    output logic        rot_b,
    output logic        rot_z,
    output logic [31:0] pos,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GET_CNT = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0]  state;
    logic        ready_en;
    logic        dir_q;
    logic [15:0] period_q;
    logic [31:0] remaining;
    logic [15:0] timer;

    logic        beat;
    logic        tick;
    logic [15:0] period_in;
    logic [31:0] pos_next;
    logic        a_next;
    logic        b_next;

    // ready_en keeps tready low while reset is held and for the reset-release edge
    assign s_axis_tready = ready_en && (state != RUN);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign busy          = (state == RUN);
    assign tick          = (state == RUN) && (timer == period_q - 16'd1);
    assign period_in     = (s_axis_tdata[15:0] < MIN_PERIOD) ? MIN_PERIOD : s_axis_tdata[15:0];

    always_comb begin
        pos_next = pos;
        a_next   = rot_a;
        b_next   = rot_b;
        if (!dir_q) begin
            pos_next = (pos == CNT_PER_REV - 32'd1) ? 32'd0 : pos + 32'd1;
            case ({rot_a, rot_b})
                2'b00:   {a_next, b_next} = 2'b10;
                2'b10:   {a_next, b_next} = 2'b11;
                2'b11:   {a_next, b_next} = 2'b01;
                default: {a_next, b_next} = 2'b00;
            endcase
        end else begin
            pos_next = (pos == 32'd0) ? CNT_PER_REV - 32'd1 : pos - 32'd1;
            case ({rot_a, rot_b})
                2'b00:   {a_next, b_next} = 2'b01;
                2'b01:   {a_next, b_next} = 2'b11;
                2'b11:   {a_next, b_next} = 2'b10;
                default: {a_next, b_next} = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Command packet parsing and step scheduling
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            period_q  <= 16'd0;
            remaining <= 32'd0;
            timer     <= 16'd0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (s_axis_tlast) begin
                            err <= 1'b1;
                        end else begin
                            dir_q    <= s_axis_tdata[31];
                            period_q <= period_in;
                            state    <= GET_CNT;
                        end
                    end
                end
                GET_CNT: begin
                    if (beat) begin
                        remaining <= s_axis_tdata;
                        timer     <= 16'd0;
                        if (s_axis_tlast) begin
                            state <= (s_axis_tdata == 32'd0) ? IDLE : RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && s_axis_tlast) begin
                        timer <= 16'd0;
                        state <= (remaining == 32'd0) ? IDLE : RUN;
                    end
                end
                default: begin
                    if (tick) begin
                        timer     <= 16'd0;
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
            endcase
        end
    end

    // Phase and position only move on a tick and otherwise hold across commands
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rot_a <= 1'b0;
            rot_b <= 1'b0;
            pos   <= 32'd0;
            rot_z <= 1'b1;
        end else if (tick) begin
            rot_a <= a_next;
            rot_b <= b_next;
            pos   <= pos_next;
            rot_z <= (pos_next == 32'd0);
        end
    end

endmodule

// File: doc/rot_quad_gen.md
ROT_QUAD_GEN -- requirements
Module: rot_quad_gen

Interface
REQ-001 SHALL have parameter CNT_PER_REV, default 32'd8000, meaning quadrature counts per revolution (Z period).
REQ-002 SHALL have parameter MIN_PERIOD, default 16'd2, meaning minimum clk cycles per quadrature step.
REQ-003 SHALL have port clk  input  1  sole clock (50 MHz device clock).
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata  input  32  command word.
REQ-006 SHALL have port s_axis_tvalid  input  1  command word valid.
REQ-007 SHALL have port s_axis_tlast  input  1  last word of command packet.
REQ-008 SHALL have port s_axis_tready  output  1  command word accepted when high with tvalid.
REQ-009 SHALL have ports rot_a, rot_b, rot_z  output  1 each  emulated encoder A, B, Z phases.
REQ-010 SHALL have port pos  output  32  emulated position, 0..CNT_PER_REV-1.
REQ-011 SHALL have port busy  output  1  high while steps are being generated.
REQ-012 SHALL have port err  output  1  sticky malformed-packet flag.

Function
REQ-013 SHALL accept a 2-word packet: word0 = {dir[31] (1 = reverse), reserved[30:16], period[15:0]}; word1 = step count (unsigned 32), tlast=1.
REQ-014 SHALL implement states IDLE, GET_CNT, RUN, DRAIN; tready = 1 in IDLE, GET_CNT, DRAIN; 0 in RUN.
REQ-015 IDLE: on tvalid&tready with tlast=0 latch dir/period, go GET_CNT; with tlast=1 discard, set err, stay IDLE.
REQ-016 GET_CNT: on beat latch count; tlast=1 -> RUN (or IDLE if count=0); tlast=0 -> set err, latch count, go DRAIN.
REQ-017 DRAIN: discard beats until a beat with tlast=1 is accepted, then RUN (or IDLE if count=0).
REQ-018 Latched period below MIN_PERIOD SHALL be replaced by MIN_PERIOD.
REQ-019 RUN: 16-bit timer starts at 0 on entry, increments each cycle; at timer = period-1 a step tick occurs, timer clears, remaining count decrements.
REQ-020 First step tick SHALL occur exactly period cycles after the RUN-entry cycle; tick when remaining = 1 returns to IDLE next cycle.
REQ-021 Phase sequence {rot_a,rot_b} forward SHALL be 00->10->11->01->00 (A leads B); reverse traverses it backwards; one transition per tick, outputs registered (change cycle after tick).
REQ-022 pos SHALL increment forward / decrement reverse per tick, wrapping CNT_PER_REV-1 -> 0 forward and 0 -> CNT_PER_REV-1 reverse.
REQ-023 rot_z SHALL equal (pos == 0), registered with pos.
REQ-024 busy SHALL be 1 exactly while in RUN.
REQ-025 err SHALL stay set until reset; it never blocks operation.
REQ-026 Phase and pos SHALL persist across commands (no reinit between packets).

Reset
REQ-027 arstn low SHALL asynchronously force: state IDLE, s_axis_tready 0 while asserted then 1 in first clk after release, rot_a=0, rot_b=0, pos=0, rot_z=1, busy=0, err=0, timer and counters 0.
REQ-028 Reset during RUN SHALL abort remaining steps immediately; no partial command resumes.

Verification
REQ-029 Word0=0x0000_0005, word1=4 (tlast) -> busy 1; {A,B} 10,11,01,00 at 5-cycle spacing; pos 1,2,3,4; busy 0 after 4th step.
REQ-030 Word0=0x8000_0003, word1=2 from pos=0 -> {A,B} 01 then 11; pos 7999 then 7998; rot_z 1->0 at first step.
REQ-031 Word0=0x0000_0000, word1=3 -> period clamped to 2; steps 2 cycles apart; err stays 0.
REQ-032 Word0 with tlast=1 -> err=1, no steps; then valid packet with count 0 -> tready stays 1, busy never asserts.
REQ-033 3-beat packet (tlast on beat 3), count=2 -> err=1, DRAIN consumes beat 3, then 2 steps executed.
REQ-034 arstn pulsed mid-RUN after 2 of 10 steps -> outputs at reset values immediately; no further edges on A/B.
